// File: rtl/pm_sort_seq.sv
// Sequential path-metric sorter: odd-even transposition sort over 2L {pm, idx}
// entries, one compare-exchange pass per cycle, returning the L smallest.
module pm_sort_seq #(
  parameter int unsigned L           = 4,
  parameter int unsigned PM_WIDTH    = 8,
  parameter int unsigned INDEX_WIDTH = $clog2(2 * L)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      sorter_en,
  input  logic [PM_WIDTH*2*L-1:0]   PM_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PM_WIDTH*L-1:0]     PM_out,
  output logic [INDEX_WIDTH*L-1:0]  sorter_res
);

  localparam int unsigned N      = 2 * L;
  localparam int unsigned PASS_W = $clog2(N);
  localparam logic [PASS_W-1:0] LAST_PASS = PASS_W'(N - 1);

  typedef enum logic [1:0] {IDLE, SORT, DONE} state_e;

  state_e                  state_q, state_d;
  logic [PASS_W-1:0]       pass_q, pass_d;
  logic [PM_WIDTH-1:0]     pm_q  [N];
  logic [PM_WIDTH-1:0]     pm_d  [N];
  logic [PM_WIDTH-1:0]     pm_x  [N];
  logic [INDEX_WIDTH-1:0]  idx_q [N];
  logic [INDEX_WIDTH-1:0]  idx_d [N];
  logic [INDEX_WIDTH-1:0]  idx_x [N];
  logic [PM_WIDTH*L-1:0]   pm_out_q, pm_out_d;
  logic [INDEX_WIDTH*L-1:0] res_q, res_d;

  // One transposition pass: pairs starting at even positions on even passes,
  // odd positions on odd passes. Pairs are disjoint, so all read from _q.
  always_comb begin
    pm_x  = pm_q;
    idx_x = idx_q;
    for (int unsigned a = 0; a + 1 < N; a++) begin
      if (1'(a) == pass_q[0]) begin
        if ((pm_q[a] > pm_q[a+1]) ||
            ((pm_q[a] == pm_q[a+1]) && (idx_q[a] > idx_q[a+1]))) begin
          pm_x[a]    = pm_q[a+1];
          pm_x[a+1]  = pm_q[a];
          idx_x[a]   = idx_q[a+1];
          idx_x[a+1] = idx_q[a];
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    pass_d   = pass_q;
    pm_d     = pm_q;
    idx_d    = idx_q;
    pm_out_d = pm_out_q;
    res_d    = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          for (int unsigned i = 0; i < N; i++) begin
            pm_d[i]  = PM_in[PM_WIDTH*(N-i)-1 -: PM_WIDTH];
            idx_d[i] = INDEX_WIDTH'(i);
          end
          pass_d = '0;
          if (sorter_en) begin
            state_d = SORT;
          end else begin
            state_d = DONE;
            for (int unsigned r = 0; r < L; r++) begin
              pm_out_d[PM_WIDTH*(L-r)-1 -: PM_WIDTH]    = PM_in[PM_WIDTH*(N-2*r)-1 -: PM_WIDTH];
              res_d[INDEX_WIDTH*(L-r)-1 -: INDEX_WIDTH] = INDEX_WIDTH'(2 * r);
            end
          end
        end
      end
      SORT: begin
        pm_d   = pm_x;
        idx_d  = idx_x;
        pass_d = pass_q + 1'b1;
        // Results are taken from the final pass's combinational output so the
        // registered outputs land together with the DONE state.
        if (pass_q == LAST_PASS) begin
          state_d = DONE;
          pass_d  = '0;
          for (int unsigned r = 0; r < L; r++) begin
            pm_out_d[PM_WIDTH*(L-r)-1 -: PM_WIDTH]    = pm_x[r];
            res_d[INDEX_WIDTH*(L-r)-1 -: INDEX_WIDTH] = idx_x[r];
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pass_q   <= '0;
      pm_out_q <= '0;
      res_q    <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        pm_q[i]  <= '0;
        idx_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pass_q   <= pass_d;
      pm_out_q <= pm_out_d;
      res_q    <= res_d;
      for (int unsigned i = 0; i < N; i++) begin
        pm_q[i]  <= pm_d[i];
        idx_q[i] <= idx_d[i];
      end
    end
  end

  assign in_ready   = (state_q == IDLE) && !rst;
  assign out_valid  = (state_q == DONE);
  assign PM_out     = pm_out_q;
  assign sorter_res = res_q;

endmodule
